// File: rtl/fp_operand_fetch_if.sv
// Issue / writeback / execute bundle for the FP operand-fetch stage.
// slave is the stage's own view; master is the view of whoever drives it.
interface fp_operand_fetch_if #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
);
    // Writeback write port
    logic            wb_fp_en;
    logic [AW-1:0]   wb_rd;
    logic [DW-1:0]   fp_wdata;

    // Issue side
    logic            id_valid;
    logic            id_ready;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [AW-1:0]   id_rd;
    logic            id_rd_we;

    // Execute side
    logic            ex_valid;
    logic            ex_ready;
    logic [DW-1:0]   ex_op_a;
    logic [DW-1:0]   ex_op_b;
    logic [AW-1:0]   ex_rd;
    logic            ex_rd_we;

    // Scoreboard visibility
    logic [NREG-1:0] busy_mask;

    modport slave (
        input  wb_fp_en, wb_rd, fp_wdata,
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
        input  ex_ready,
        output id_ready,
        output ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we,
        output busy_mask
    );

    modport master (
        output wb_fp_en, wb_rd, fp_wdata,
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
        output ex_ready,
        input  id_ready,
        input  ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we,
        input  busy_mask
    );
endinterface

// File: rtl/fp_operand_fetch.sv
// FP operand fetch: owns the FP register file and busy scoreboard, bypasses
// same-cycle writeback data, stalls on RAW/WAW hazards and hands a registered
// operand bundle to FP execute through a valid/ready handshake.
module fp_operand_fetch #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    fp_operand_fetch_if.slave   bus_io
);

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;

    logic            ex_valid_q, ex_valid_d;
    logic [DW-1:0]   ex_op_a_q, ex_op_a_d;
    logic [DW-1:0]   ex_op_b_q, ex_op_b_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic            ex_rd_we_q, ex_rd_we_d;

    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] eff_busy;
    logic [DW-1:0]   rs1_val, rs2_val;
    logic            hz_a, hz_b, hz_w;
    logic            id_ready;
    logic            accept;

    // One-hot of the register being written back this cycle (zero if none).
    always_comb begin
        wb_hit = '0;
        if (bus_io.wb_fp_en) begin
            wb_hit[bus_io.wb_rd] = 1'b1;
        end
    end

    // A writeback landing this cycle resolves the hazard on its register now.
    assign eff_busy = busy_q & ~wb_hit;

    // Source reads with writeback bypass.
    always_comb begin
        rs1_val = regs_q[bus_io.id_rs1];
        rs2_val = regs_q[bus_io.id_rs2];
        if (bus_io.wb_fp_en && (bus_io.wb_rd == bus_io.id_rs1)) begin
            rs1_val = bus_io.fp_wdata;
        end
        if (bus_io.wb_fp_en && (bus_io.wb_rd == bus_io.id_rs2)) begin
            rs2_val = bus_io.fp_wdata;
        end
    end

    // Hazard detection and issue handshake; id_ready ignores id_valid.
    always_comb begin
        hz_a     = bus_io.id_use_rs1 & eff_busy[bus_io.id_rs1];
        hz_b     = bus_io.id_use_rs2 & eff_busy[bus_io.id_rs2];
        hz_w     = bus_io.id_rd_we   & eff_busy[bus_io.id_rd];
        id_ready = ~(hz_a | hz_b | hz_w) & (~ex_valid_q | bus_io.ex_ready);
        accept   = bus_io.id_valid & id_ready;
    end

    // Scoreboard next state: clear on writeback, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (accept && bus_io.id_rd_we) begin
            busy_d[bus_io.id_rd] = 1'b1;
        end
    end

    // Execute bundle next state; data holds unless a new bundle is accepted.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_a_d  = ex_op_a_q;
        ex_op_b_d  = ex_op_b_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_we_d = ex_rd_we_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_op_a_d  = rs1_val;
            ex_op_b_d  = rs2_val;
            ex_rd_d    = bus_io.id_rd;
            ex_rd_we_d = bus_io.id_rd_we;
        end else if (bus_io.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Register file write port; f0 is an ordinary writable register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus_io.wb_fp_en) begin
            regs_q[bus_io.wb_rd] <= bus_io.fp_wdata;
        end
    end

    // Scoreboard and execute bundle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op_a_q  <= '0;
            ex_op_b_q  <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_op_a_q  <= ex_op_a_d;
            ex_op_b_q  <= ex_op_b_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_we_q <= ex_rd_we_d;
        end
    end

    assign bus_io.id_ready  = id_ready;
    assign bus_io.ex_valid  = ex_valid_q;
    assign bus_io.ex_op_a   = ex_op_a_q;
    assign bus_io.ex_op_b   = ex_op_b_q;
    assign bus_io.ex_rd     = ex_rd_q;
    assign bus_io.ex_rd_we  = ex_rd_we_q;
    assign bus_io.busy_mask = busy_q;

endmodule

// File: tb/tb_fp_operand_fetch.sv
// Self-checking bench for fp_operand_fetch: directed scenarios plus a
// randomized run against a behavioural register-file/scoreboard model.
module tb_fp_operand_fetch;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_operand_fetch_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus ();

    fp_operand_fetch #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_busy;
    logic            m_ex_valid;
    logic [DW-1:0]   m_a, m_b;
    logic [AW-1:0]   m_rd;
    logic            m_rdwe;

    function automatic logic m_ready();
        logic [NREG-1:0] eb;
        eb = m_busy;
        if (bus.wb_fp_en) eb[bus.wb_rd] = 1'b0;
        if (bus.id_use_rs1 && eb[bus.id_rs1]) return 1'b0;
        if (bus.id_use_rs2 && eb[bus.id_rs2]) return 1'b0;
        if (bus.id_rd_we && eb[bus.id_rd]) return 1'b0;
        return !m_ex_valid || bus.ex_ready;
    endfunction

    task automatic m_step();
        logic acc;
        logic [DW-1:0] a, b;
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
            m_busy = '0; m_ex_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_rdwe = 1'b0;
            return;
        end
        acc = bus.id_valid && m_ready();
        a = (bus.wb_fp_en && bus.wb_rd == bus.id_rs1) ? bus.fp_wdata : m_regs[bus.id_rs1];
        b = (bus.wb_fp_en && bus.wb_rd == bus.id_rs2) ? bus.fp_wdata : m_regs[bus.id_rs2];
        if (bus.wb_fp_en) begin
            m_regs[bus.wb_rd] = bus.fp_wdata;
            m_busy[bus.wb_rd] = 1'b0;
        end
        if (acc) begin
            m_ex_valid = 1'b1; m_a = a; m_b = b; m_rd = bus.id_rd; m_rdwe = bus.id_rd_we;
            if (bus.id_rd_we) m_busy[bus.id_rd] = 1'b1;
        end else if (bus.ex_ready) begin
            m_ex_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_fp_en = 0; bus.wb_rd = '0; bus.fp_wdata = '0;
        bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = '0; bus.id_rd_we = 0;
        bus.ex_ready = 1;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2,
                         input logic [AW-1:0] rd, input logic we);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rd = rd; bus.id_rd_we = we;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.wb_fp_en = 1; bus.wb_rd = 5'd6; bus.fp_wdata = 32'hDEAD_BEEF;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        idle_inputs();
        n_cmp++;
        if (bus.ex_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_ex_valid got %0b want 0", bus.ex_valid);
        end
        n_cmp++;
        if (bus.busy_mask !== '0) begin
            n_err++; $display("FAIL reset_busy got %h want 0", bus.busy_mask);
        end
        n_cmp++;
        if (bus.ex_op_a !== '0 || bus.ex_op_b !== '0 || bus.ex_rd !== '0 || bus.ex_rd_we !== 1'b0)
        begin
            n_err++;
            $display("FAIL reset_ex_data got a=%h b=%h rd=%0d we=%0b want all 0",
                     bus.ex_op_a, bus.ex_op_b, bus.ex_rd, bus.ex_rd_we);
        end
    endtask

    task automatic test_basic_issue();
        idle_inputs();
        issue(5'd3, 5'd4, 1, 1, 5'd0, 0);
        #1;
        n_cmp++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_ready got %0b want 1", bus.id_ready);
        end
        cycle();
        idle_inputs();
        n_cmp++;
        if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 32'h0 || bus.ex_op_b !== 32'h0) begin
            n_err++;
            $display("FAIL basic_bundle got v=%0b a=%h b=%h want v=1 a=0 b=0",
                     bus.ex_valid, bus.ex_op_a, bus.ex_op_b);
        end
        n_cmp++;
        if (bus.busy_mask !== '0) begin
            n_err++; $display("FAIL basic_busy got %h want 0", bus.busy_mask);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.wb_fp_en = 1; bus.wb_rd = 5'd5; bus.fp_wdata = 32'h3F80_0000;
        issue(5'd5, 5'd0, 1, 0, 5'd0, 0);
        #1;
        n_cmp++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL bypass_ready got %0b want 1", bus.id_ready);
        end
        cycle();
        idle_inputs();
        n_cmp++;
        if (bus.ex_op_a !== 32'h3F80_0000) begin
            n_err++; $display("FAIL bypass_op_a got %h want 3f800000", bus.ex_op_a);
        end
    endtask

    task automatic test_raw_stall();
        idle_inputs();
        issue(5'd0, 5'd0, 0, 0, 5'd7, 1);
        cycle();
        idle_inputs();
        issue(5'd0, 5'd7, 0, 1, 5'd8, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (bus.id_ready !== 1'b0 || bus.busy_mask[7] !== 1'b1) begin
                n_err++;
                $display("FAIL raw_stall cycle %0d got ready=%0b busy7=%0b want ready=0 busy7=1",
                         k, bus.id_ready, bus.busy_mask[7]);
            end
            cycle();
        end
        bus.wb_fp_en = 1; bus.wb_rd = 5'd7; bus.fp_wdata = 32'h4000_0000;
        #1;
        n_cmp++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL raw_release_ready got %0b want 1", bus.id_ready);
        end
        cycle();
        idle_inputs();
        n_cmp++;
        if (bus.ex_op_b !== 32'h4000_0000 || bus.ex_rd !== 5'd8 || bus.busy_mask[7] !== 1'b0) begin
            n_err++;
            $display("FAIL raw_release got b=%h rd=%0d busy7=%0b want b=40000000 rd=8 busy7=0",
                     bus.ex_op_b, bus.ex_rd, bus.busy_mask[7]);
        end
    endtask

    task automatic test_set_clear();
        idle_inputs();
        issue(5'd0, 5'd0, 0, 0, 5'd9, 1);
        cycle();
        idle_inputs();
        bus.wb_fp_en = 1; bus.wb_rd = 5'd9; bus.fp_wdata = 32'h1234_5678;
        issue(5'd0, 5'd0, 0, 0, 5'd9, 1);
        #1;
        n_cmp++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL setclr_ready got %0b want 1", bus.id_ready);
        end
        cycle();
        idle_inputs();
        n_cmp++;
        if (bus.busy_mask[9] !== 1'b1) begin
            n_err++; $display("FAIL setclr_busy9 got %0b want 1", bus.busy_mask[9]);
        end
        bus.wb_fp_en = 1; bus.wb_rd = 5'd9; bus.fp_wdata = 32'h0;
        cycle();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a0, b0;
        idle_inputs();
        bus.wb_fp_en = 1; bus.wb_rd = 5'd10; bus.fp_wdata = 32'hAAAA_0001;
        cycle();
        bus.wb_rd = 5'd11; bus.fp_wdata = 32'hBBBB_0002;
        cycle();
        idle_inputs();
        issue(5'd10, 5'd11, 1, 1, 5'd12, 0);
        cycle();
        a0 = 32'hAAAA_0001; b0 = 32'hBBBB_0002;
        bus.ex_ready = 0;
        issue(5'd11, 5'd10, 1, 1, 5'd13, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (bus.id_ready !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_op_a !== a0 ||
                bus.ex_op_b !== b0 || bus.ex_rd !== 5'd12) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got ready=%0b v=%0b a=%h b=%h rd=%0d",
                         k, bus.id_ready, bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd);
            end
            cycle();
        end
        bus.ex_ready = 1;
        #1;
        n_cmp++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready got %0b want 1", bus.id_ready);
        end
        cycle();
        idle_inputs();
        n_cmp++;
        if (bus.ex_op_a !== b0 || bus.ex_op_b !== a0 || bus.ex_rd !== 5'd13) begin
            n_err++;
            $display("FAIL bp_next got a=%h b=%h rd=%0d want a=%h b=%h rd=13",
                     bus.ex_op_a, bus.ex_op_b, bus.ex_rd, b0, a0);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.wb_fp_en = 1; bus.wb_rd = 5'd1; bus.fp_wdata = 32'hCAFE_F00D;
        cycle();
        idle_inputs();
        issue(5'd0, 5'd0, 0, 0, 5'd1, 1);
        cycle();
        issue(5'd0, 5'd0, 0, 0, 5'd2, 1);
        cycle();
        idle_inputs();
        bus.ex_ready = 0;
        rst = 1;
        cycle();
        rst = 0;
        bus.ex_ready = 1;
        n_cmp++;
        if (bus.ex_valid !== 1'b0 || bus.busy_mask !== '0) begin
            n_err++;
            $display("FAIL rstmid got v=%0b busy=%h want v=0 busy=0", bus.ex_valid, bus.busy_mask);
        end
        issue(5'd1, 5'd2, 1, 1, 5'd0, 0);
        cycle();
        idle_inputs();
        n_cmp++;
        if (bus.ex_op_a !== 32'h0) begin
            n_err++; $display("FAIL rstmid_read got %h want 0", bus.ex_op_a);
        end
    endtask

    task automatic test_random();
        logic [NREG-1:0] eb;
        for (int n = 0; n < 1500; n++) begin
            bus.wb_fp_en   = ($urandom_range(0, 2) == 0);
            bus.wb_rd      = AW'($urandom_range(0, 7));
            bus.fp_wdata   = $urandom;
            bus.id_valid   = ($urandom_range(0, 3) != 0);
            bus.id_rs1     = AW'($urandom_range(0, 7));
            bus.id_rs2     = AW'($urandom_range(0, 7));
            bus.id_use_rs1 = 1'($urandom);
            bus.id_use_rs2 = 1'($urandom);
            bus.id_rd      = AW'($urandom_range(0, 7));
            bus.id_rd_we   = 1'($urandom);
            bus.ex_ready   = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 199) == 0);
            #1;
            n_cmp++;
            if (bus.id_ready !== m_ready()) begin
                n_err++;
                $display("FAIL rand_ready iter %0d got %0b want %0b", n, bus.id_ready, m_ready());
            end
            cycle();
            rst = 0;
            eb = m_busy;
            n_cmp++;
            if (bus.ex_valid !== m_ex_valid || bus.ex_op_a !== m_a || bus.ex_op_b !== m_b ||
                bus.ex_rd !== m_rd || bus.ex_rd_we !== m_rdwe || bus.busy_mask !== eb) begin
                n_err++;
                $display("FAIL rand_state iter %0d got v=%0b a=%h b=%h rd=%0d we=%0b busy=%h want v=%0b a=%h b=%h rd=%0d we=%0b busy=%h",
                         n, bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd, bus.ex_rd_we,
                         bus.busy_mask, m_ex_valid, m_a, m_b, m_rd, m_rdwe, eb);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic_issue();
        test_bypass();
        test_raw_stall();
        test_set_clear();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
